// File: rtl/srff_from_jkff_bank.sv
// rtl/srff_from_jkff_bank.sv - SR-command register bank built from JK cells with forbidden-input accounting
// Optional build macro: SRFF_SET_DOMINANT_EN (s=r=1 becomes a legal set, error tracking tied off).
module srff_from_jkff_bank #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     s,
    input  logic [WIDTH-1:0]     r,
    input  logic                 err_clr,
    output logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 illegal_flag,
    output logic [WIDTH-1:0]     illegal_bits,
    output logic [ERR_CNT_W-1:0] illegal_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] s_l;
    logic [WIDTH-1:0] r_l;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

`ifdef SRFF_SET_DOMINANT_EN
    assign j = s_l;
    assign k = r_l & ~s_l;
`else
    logic [WIDTH-1:0] ill;
    assign ill = s_l & r_l;
    assign j   = s_l & ~r_l;
    assign k   = r_l & ~s_l;
`endif

    // Conversion must never present a JK toggle to any cell.
    always_comb begin
        assert ((j & k) == '0);
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = APPLY;
`ifdef SRFF_SET_DOMINANT_EN
            APPLY:   state_next = IDLE;
`else
            APPLY:   state_next = (ill != '0) ? ERROR : IDLE;
`endif
            ERROR:   if (err_clr) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            s_l   <= '0;
            r_l   <= '0;
            q     <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && cmd_valid) begin
                s_l <= s;
                r_l <= r;
            end
            if (state == APPLY) begin
                q <= (j & ~q) | (~k & q);
            end
        end
    end

`ifdef SRFF_SET_DOMINANT_EN
    assign illegal_flag = 1'b0;
    assign illegal_bits = '0;
    assign illegal_cnt  = '0;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_flag <= 1'b0;
            illegal_bits <= '0;
            illegal_cnt  <= '0;
        end else begin
            if (state == APPLY && ill != '0) begin
                // A coincident err_clr drops history but the fresh illegal bits still register.
                illegal_flag <= 1'b1;
                illegal_bits <= err_clr ? ill : (illegal_bits | ill);
                if (illegal_cnt != '1) begin
                    illegal_cnt <= illegal_cnt + 1'b1;
                end
            end else if (err_clr) begin
                illegal_flag <= 1'b0;
                illegal_bits <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_srff_from_jkff_bank.sv
// tb/tb_srff_from_jkff_bank.sv - randomized self-checking bench for srff_from_jkff_bank
module tb_srff_from_jkff_bank;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [W-1:0]  s = '0;
    logic [W-1:0]  r = '0;
    logic          err_clr = 1'b0;
    logic [W-1:0]  q;
    logic          busy;
    logic          illegal_flag;
    logic [W-1:0]  illegal_bits;
    logic [CW-1:0] illegal_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0]  q_m    = '0;
    logic          flag_m = 1'b0;
    logic [W-1:0]  bits_m = '0;
    int            cnt_m  = 0;

    srff_from_jkff_bank #(.WIDTH(W), .ERR_CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .s            (s),
        .r            (r),
        .err_clr      (err_clr),
        .q            (q),
        .busy         (busy),
        .illegal_flag (illegal_flag),
        .illegal_bits (illegal_bits),
        .illegal_cnt  (illegal_cnt)
    );

    always #5 clk = ~clk;

    // Set wins where s=r=1 in set-dominant builds, otherwise those bits are forbidden and hold.
    function automatic logic [W-1:0] model_q(input logic [W-1:0] qo, input logic [W-1:0] sv, input logic [W-1:0] rv);
`ifdef SRFF_SET_DOMINANT_EN
        return (qo & ~(rv & ~sv)) | sv;
`else
        return (qo & ~(rv & ~sv)) | (sv & ~rv);
`endif
    endfunction

    function automatic logic [W-1:0] model_ill(input logic [W-1:0] sv, input logic [W-1:0] rv);
`ifdef SRFF_SET_DOMINANT_EN
        return '0;
`else
        return sv & rv;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [W-1:0] sv, input logic [W-1:0] rv, input logic clr_in_apply);
        logic [W-1:0] ill;
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL ready_wait cmd_ready=%b required 1", cmd_ready);
        else n_pass++;

        cmd_valid = 1'b1; s = sv; r = rv;
        tick();
        cmd_valid = 1'b0; s = $urandom; r = $urandom;
        err_clr = clr_in_apply;
        n_checks++;
        if ({cmd_ready, busy, q} !== {1'b0, 1'b1, q_m})
            $display("FAIL apply_phase ready/busy/q=%b/%b/%h required 0/1/%h", cmd_ready, busy, q, q_m);
        else n_pass++;

        tick();
        err_clr = 1'b0;
        ill = model_ill(sv, rv);
        q_m = model_q(q_m, sv, rv);
        if (ill != '0) begin
            flag_m = 1'b1;
            bits_m = clr_in_apply ? ill : (bits_m | ill);
            if (cnt_m < 15) cnt_m++;
        end else if (clr_in_apply) begin
`ifndef SRFF_SET_DOMINANT_EN
            flag_m = 1'b0;
            bits_m = '0;
`endif
        end
        n_checks++;
        if ({q, illegal_flag, illegal_bits, illegal_cnt, cmd_ready} !==
            {q_m, flag_m, bits_m, cnt_m[CW-1:0], (ill == '0)})
            $display("FAIL update q=%h flag=%b bits=%h cnt=%0d ready=%b required q=%h flag=%b bits=%h cnt=%0d ready=%b",
                     q, illegal_flag, illegal_bits, illegal_cnt, cmd_ready, q_m, flag_m, bits_m, cnt_m, (ill == '0));
        else n_pass++;

        if (ill != '0) begin
            err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            flag_m = 1'b0;
            bits_m = '0;
            n_checks++;
            if ({illegal_flag, illegal_bits, illegal_cnt, cmd_ready, q} !== {1'b0, 8'h00, cnt_m[CW-1:0], 1'b1, q_m})
                $display("FAIL err_clear flag=%b bits=%h cnt=%0d ready=%b q=%h required 0/00/%0d/1/%h",
                         illegal_flag, illegal_bits, illegal_cnt, cmd_ready, q, cnt_m, q_m);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({q, illegal_flag, illegal_bits, illegal_cnt, cmd_ready, busy} !== {8'h00, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0})
            $display("FAIL reset_state q=%h flag=%b bits=%h cnt=%0d ready=%b busy=%b", q, illegal_flag, illegal_bits, illegal_cnt, cmd_ready, busy);
        else n_pass++;

        cmd_valid = 1'b1; s = 8'hFF; r = 8'h00;
        tick();
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({q, cmd_ready, busy} !== {8'h00, 1'b1, 1'b0})
            $display("FAIL reset_mid_apply q=%h ready=%b busy=%b required 00/1/0", q, cmd_ready, busy);
        else n_pass++;
        #3;
        rst_n = 1'b1;
        q_m = '0; flag_m = 1'b0; bits_m = '0; cnt_m = 0;
        repeat (3) tick();
        n_checks++;
        if (q !== 8'h00) $display("FAIL reset_release_hold q=%h required 00", q);
        else n_pass++;
    endtask

    task automatic test_set_reset_hold();
        send_cmd(8'h0F, 8'h00, 1'b0);
        send_cmd(8'h00, 8'h03, 1'b0);
        send_cmd(8'h00, 8'h00, 1'b0);
        n_checks++;
`ifdef SRFF_SET_DOMINANT_EN
        if (q !== 8'h0C) $display("FAIL set_reset_hold q=%h required 0c", q);
`else
        if (q !== 8'h0C) $display("FAIL set_reset_hold q=%h required 0c", q);
`endif
        else n_pass++;
    endtask

    task automatic test_illegal();
        send_cmd(8'h81, 8'h84, 1'b0);
        n_checks++;
`ifdef SRFF_SET_DOMINANT_EN
        if ({q, illegal_cnt} !== {8'h89, 4'h0}) $display("FAIL illegal_cmd q=%h cnt=%0d required 89/0", q, illegal_cnt);
`else
        if ({q, illegal_cnt} !== {8'h09, 4'h1}) $display("FAIL illegal_cmd q=%h cnt=%0d required 09/1", q, illegal_cnt);
`endif
        else n_pass++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) send_cmd(8'h01, 8'h01, 1'b0);
        n_checks++;
`ifdef SRFF_SET_DOMINANT_EN
        if (illegal_cnt !== 4'h0) $display("FAIL saturation cnt=%0d required 0", illegal_cnt);
`else
        if (illegal_cnt !== 4'hF) $display("FAIL saturation cnt=%0d required f", illegal_cnt);
`endif
        else n_pass++;
    endtask

    task automatic test_handshake_stall();
        logic         ready_m;
        logic [W-1:0] ps;
        logic [W-1:0] pr;
        ready_m = 1'b1;
        ps = '0; pr = '0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            s = $urandom;
            r = $urandom & ~s;
            tick();
            if (ready_m) begin
                ps = s; pr = r; ready_m = 1'b0;
            end else begin
                q_m = model_q(q_m, ps, pr);
                ready_m = 1'b1;
            end
            n_checks++;
            if ({q, cmd_ready} !== {q_m, ready_m})
                $display("FAIL stall_cycle%0d q=%h ready=%b required %h/%b", i, q, cmd_ready, q_m, ready_m);
            else n_pass++;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [W-1:0] sv;
        logic [W-1:0] rv;
        for (int i = 0; i < 40; i++) begin
            sv = $urandom;
            rv = $urandom;
            if ($urandom_range(0, 2) != 0) rv = rv & ~sv;
            send_cmd(sv, rv, ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_set_reset_hold();
        test_illegal();
        test_saturation();
        test_handshake_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
